// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD pixel-FIFO fetch scheduler.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT
  } state_t;

  localparam int BOUNDARY_4K   = 4096;
  localparam int FRAME_WORDS_W = 24;
  localparam int LEN_W         = 8;

endpackage

// File: rtl/lcd_burst_len_calc.sv
// Burst length = min(BURST_LEN, words remaining, words left before the next 4 KB boundary).
module lcd_burst_len_calc
  import lcd_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int BURST_LEN      = 16
) (
  input  logic [FRAME_WORDS_W-1:0] i_remain,
  input  logic [11:0]              i_addr_lo,
  output logic [LEN_W-1:0]         o_len
);

  localparam int SHIFT = $clog2(BYTES_PER_WORD);

  logic [12:0]              w_bytes_to_bnd;
  logic [12:0]              w_bnd_words;
  logic [FRAME_WORDS_W-1:0] w_min;

  assign w_bytes_to_bnd = 13'(BOUNDARY_4K) - {1'b0, i_addr_lo};
  assign w_bnd_words    = w_bytes_to_bnd >> SHIFT;

  // NOTE: w_min gets a default before any conditional update so no latch is inferred.
  always_comb begin
    w_min = FRAME_WORDS_W'(BURST_LEN);
    if (i_remain < w_min)
      w_min = i_remain;
    if (FRAME_WORDS_W'(w_bnd_words) < w_min)
      w_min = FRAME_WORDS_W'(w_bnd_words);
  end

  assign o_len = LEN_W'(w_min);

endmodule

// File: rtl/lcd_fetch_sched.sv
// Walks a frame buffer issuing one outstanding read burst at a time to keep the LCD pixel FIFO fed.
module lcd_fetch_sched
  import lcd_pkg::*;
#(
  parameter int ADDR_W                = 32,
  parameter int BYTES_PER_WORD        = 4,
  parameter int BURST_LEN             = 16,
  parameter int FIFO_ALMOSTFULL_DEPTH = 1008
) (
  input  logic                     fifo_wr_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_start,
  input  logic [ADDR_W-1:0]        frame_base,
  input  logic [FRAME_WORDS_W-1:0] frame_words,
  input  logic [9:0]               fifo_wr_cnt,
  input  logic                     fifo_full,
  output logic                     burst_req,
  output logic [ADDR_W-1:0]        burst_addr,
  output logic [LEN_W-1:0]         burst_len,
  input  logic                     burst_ack,
  input  logic                     burst_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_overrun
);

  localparam int SHIFT = $clog2(BYTES_PER_WORD);

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_addr;
  logic [FRAME_WORDS_W-1:0] r_remain;
  logic                     r_pend;
  logic [ADDR_W-1:0]        r_pend_base;
  logic [FRAME_WORDS_W-1:0] r_pend_words;
  logic                     r_burst_req;
  logic [ADDR_W-1:0]        r_burst_addr;
  logic [LEN_W-1:0]         r_burst_len;
  logic                     r_frame_done;
  logic                     r_frame_overrun;

  logic [LEN_W-1:0]         w_len;
  logic                     w_go;
  logic [ADDR_W-1:0]        w_step;
  logic [ADDR_W-1:0]        w_next_base;
  logic [FRAME_WORDS_W-1:0] w_next_words;

  lcd_burst_len_calc #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BURST_LEN      (BURST_LEN)
  ) u_len_calc (
    .i_remain  (r_remain),
    .i_addr_lo (r_addr[11:0]),
    .o_len     (w_len)
  );

  assign w_go   = enable && !fifo_full &&
                  ({1'b0, fifo_wr_cnt} < 11'(FIFO_ALMOSTFULL_DEPTH));
  assign w_step = ADDR_W'(r_burst_len) << SHIFT;

  // A frame_start coincident with burst_done takes precedence over any older pending frame.
  assign w_next_base  = frame_start ? frame_base  : r_pend_base;
  assign w_next_words = frame_start ? frame_words : r_pend_words;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge fifo_wr_clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_remain        <= '0;
      r_pend          <= 1'b0;
      r_pend_base     <= '0;
      r_pend_words    <= '0;
      r_burst_req     <= 1'b0;
      r_burst_addr    <= '0;
      r_burst_len     <= '0;
      r_frame_done    <= 1'b0;
      r_frame_overrun <= 1'b0;
    end else begin
      r_frame_done    <= 1'b0;
      r_frame_overrun <= frame_start && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            if (frame_words != '0) begin
              r_addr   <= frame_base;
              r_remain <= frame_words;
              r_state  <= ST_CHECK;
            end else begin
              r_frame_done <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          if (frame_start) begin
            if (frame_words != '0) begin
              r_addr   <= frame_base;
              r_remain <= frame_words;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end else if (w_go) begin
            r_burst_req  <= 1'b1;
            r_burst_addr <= r_addr;
            r_burst_len  <= w_len;
            r_state      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (frame_start) begin
            r_pend       <= 1'b1;
            r_pend_base  <= frame_base;
            r_pend_words <= frame_words;
          end
          if (burst_ack) begin
            r_burst_req <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (burst_done) begin
            r_pend <= 1'b0;
            if (frame_start || r_pend) begin
              r_addr   <= w_next_base;
              r_remain <= w_next_words;
              if (w_next_words != '0) begin
                r_state <= ST_CHECK;
              end else begin
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end else begin
              r_addr   <= r_addr + w_step;
              r_remain <= r_remain - FRAME_WORDS_W'(r_burst_len);
              if (r_remain == FRAME_WORDS_W'(r_burst_len)) begin
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end else begin
                r_state <= ST_CHECK;
              end
            end
          end else if (frame_start) begin
            r_pend       <= 1'b1;
            r_pend_base  <= frame_base;
            r_pend_words <= frame_words;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign burst_req     = r_burst_req;
  assign burst_addr    = r_burst_addr;
  assign burst_len     = r_burst_len;
  assign busy          = (r_state != ST_IDLE);
  assign frame_done    = r_frame_done;
  assign frame_overrun = r_frame_overrun;

endmodule

// File: doc/lcd_fetch_sched.md
Name: lcd_fetch_sched

Overview:
- Write-side scheduler for the LCD pixel FIFO.
- Walks a frame buffer in memory and issues read-burst requests to the AXI master so the FIFO stays above its drain threshold while the read-side controller feeds the LCD.
- Sits between the frame-sync logic (frame_start), the AXI read master (burst handshake) and the FIFO write-side status.
- Keeps one burst outstanding at a time.

Parameters:
ADDR_W, 32, byte-address width of the frame buffer.
BYTES_PER_WORD, 4, bytes per FIFO word; power of two.
BURST_LEN, 16, maximum words per burst (1..255).
FIFO_ALMOSTFULL_DEPTH, 1008, a burst is issued only when fifo_wr_cnt is below this value.

Ports:
fifo_wr_clk  input  1  FIFO write-side clock; the only clock.
rst  input  1  asynchronous, active-high reset.
enable  input  1  level; 0 inhibits new bursts.
frame_start  input  1  one-cycle pulse; starts fetching a new frame.
frame_base  input  ADDR_W  byte address of the frame; sampled on frame_start; word-aligned.
frame_words  input  24  frame size in words; sampled on frame_start.
fifo_wr_cnt  input  10  FIFO write-side fill level.
fifo_full  input  1  FIFO full flag.
burst_req  output  1  burst request; held until burst_ack.
burst_addr  output  ADDR_W  start byte address of the burst.
burst_len  output  8  burst length in words (1..BURST_LEN).
burst_ack  input  1  master accepted the request (same cycle as burst_req counts).
burst_done  input  1  one-cycle pulse; last word of the burst has been written to the FIFO.
busy  output  1  frame fetch in progress.
frame_done  output  1  one-cycle pulse; final burst of the frame has completed.
frame_overrun  output  1  one-cycle pulse; frame_start arrived while busy.

Behaviour:
- Reset values: all outputs 0. State IDLE. Address and remaining-word counters 0. Pending-frame flag 0.
- States:
  - IDLE: on frame_start with frame_words != 0, load addr=frame_base and remain=frame_words, then go to CHECK. frame_words==0 produces a frame_done pulse and stays in IDLE.
  - CHECK: if enable && !fifo_full && fifo_wr_cnt < FIFO_ALMOSTFULL_DEPTH, compute len and go to REQ, with burst_req=1 registered on the next cycle.
  - REQ: burst_req, burst_addr and burst_len are stable until burst_ack. On ack, drop burst_req the next cycle and go to WAIT.
  - WAIT: on burst_done, addr += len*BYTES_PER_WORD and remain -= len. If remain==0, pulse frame_done and go to IDLE; otherwise go to CHECK.
- len = min(BURST_LEN, remain, words to the next 4 KB boundary), where words to boundary = (4096 - addr[11:0]) / BYTES_PER_WORD. A burst never crosses a 4 KB boundary. len is always >= 1 when issued.
- Address arithmetic wraps modulo 2^ADDR_W. No error on wrap.
- busy = (state != IDLE).
- Latency: from entering CHECK with the condition true, burst_req asserts one cycle later. From burst_done to the next burst_req is at least 2 cycles.
- frame_start while busy:
  - Pulse frame_overrun (registered, 1 cycle).
  - In CHECK: reload immediately. The current frame is abandoned.
  - In REQ or WAIT: latch frame_base/frame_words as pending. The request is never withdrawn and the outstanding burst is never aborted. On burst_done, load the pending frame and go to CHECK; no frame_done for the abandoned frame.
  - A second frame_start while pending overwrites the pending values and pulses frame_overrun again.
- frame_start in the same cycle as the final burst_done: the frame_done pulse is suppressed and the new frame is loaded. frame_overrun pulses.
- enable=0: does not affect REQ or WAIT. CHECK simply waits.
- burst_ack or burst_done outside the expected state is ignored.
- Reset mid-operation: everything returns to reset values immediately. The master is reset by the same rst.

Decomposition:
- Shared package lcd_pkg holds:
  - state encoding constants (IDLE, CHECK, REQ, WAIT);
  - the 4 KB boundary constant (4096);
  - the frame_words width constant (24).
- One natural sub-module, lcd_burst_len_calc: combinational min(BURST_LEN, remain, boundary words). Instantiated once and registered in the scheduler when moving CHECK->REQ.

Test Plan:
- Basic frame: frame_base=0x1000_0000, frame_words=40, fifo_wr_cnt=0, ack and done immediate. Expect bursts (0x10000000,16), (0x10000040,16), (0x10000080,8), then one frame_done pulse and busy=0.
- 4 KB split: frame_base=0x0000_0FF0, frame_words=16. Expect bursts (0xFF0,4) then (0x1000,12).
- Throttle: fifo_wr_cnt=1008. Expect no burst_req for 100 cycles. Drop fifo_wr_cnt to 1007; expect burst_req 2 cycles later. fifo_full=1 with cnt=0 also blocks.
- Request hold: burst_ack delayed 7 cycles. Expect burst_req, burst_addr and burst_len constant throughout; burst_req low the cycle after ack.
- Overrun: frame_start (base 0x2000, words 32) while in WAIT. Expect frame_overrun 1 cycle, no frame_done, and after burst_done the next burst is (0x2000,16).
- Async reset: assert rst mid-REQ. Expect burst_req, busy and frame_done all 0 in the same cycle. After release, no burst until a new frame_start.
